// File: rtl/muldiv_unit.sv
// Unsigned 32-bit multiply/divide unit: one bit per cycle (shift-add / restoring divide).
// Start/busy/done handshake; result written back to the register file in a one-cycle WB pulse.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int AW    = 3,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [AW-1:0]    dst,
  output logic             busy,
  output logic             done,
  output logic             we,
  output logic [AW-1:0]    wa,
  output logic [WIDTH-1:0] wd,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [AW-1:0]    dst_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             dbz_q;
  logic             zero_div;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH:0]   rem_sh, diff;
  logic             q_bit;
  logic [WIDTH-1:0] div_hi, div_lo;
  logic [WIDTH-1:0] step_hi, step_lo, result;

  assign zero_div = op[1] && (b == '0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = zero_div ? WB : RUN;
      RUN:  if (cnt == '0) state_nxt = WB;
      WB:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Multiply: {hi_q, lo_q} is the product register; multiplier bits leave from lo_q[0].
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
  end

  // Divide: hi_q holds the partial remainder, lo_q the dividend turning into the quotient.
  // The remainder is always below the divisor, so the 33rd bit only exists transiently.
  always_comb begin
    rem_sh = {hi_q, lo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, b_q};
    q_bit  = ~diff[WIDTH];
    div_hi = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    div_lo = {lo_q[WIDTH-2:0], q_bit};
  end

  // op[0] selects the high half for both families: MULHI and REMU.
  always_comb begin
    step_hi = op_q[1] ? div_hi : mul_hi;
    step_lo = op_q[1] ? div_lo : mul_lo;
    result  = op_q[0] ? step_hi : step_lo;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt   <= '0;
      op_q  <= '0;
      dst_q <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      dbz_q <= 1'b0;
      wa    <= '0;
      wd    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            dst_q <= dst;
            b_q   <= b;
            hi_q  <= '0;
            lo_q  <= a;
            cnt   <= CW'(WIDTH - 1);
            dbz_q <= zero_div;
            if (zero_div) begin
              wa <= dst;
              wd <= op[0] ? a : '1;
            end
          end
        end
        RUN: begin
          hi_q <= step_hi;
          lo_q <= step_lo;
          cnt  <= cnt - CW'(1);
          if (cnt == '0) begin
            wa <= dst_q;
            wd <= result;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign we          = (state == WB);
  assign done        = we;
  assign div_by_zero = we && dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected write-backs queued at start, checked on we.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [2:0]  dst;
  logic        busy, done, we, div_by_zero;
  logic [2:0]  wa;
  logic [31:0] wd;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  wa;
    logic [31:0] wd;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];

  muldiv_unit dut (
    .clk(clk), .n_rst(n_rst), .start(start), .op(op), .a(a), .b(b), .dst(dst),
    .busy(busy), .done(done), .we(we), .wa(wa), .wd(wd), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    p = {32'b0, x} * {32'b0, y};
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (y == 0) ? 32'hFFFFFFFF : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Called at a negedge while idle; start is sampled at the next posedge (E0).
  task automatic drive(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic [2:0] d);
    exp_t e;
    e.wa  = d;
    e.wd  = model(o, x, y);
    e.dbz = o[1] && (y == 0);
    e.lat = e.dbz ? 0 : 32;
    sb.push_back(e);
    op = o; a = x; b = y; dst = d; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom; dst = 3'($urandom);
  endtask

  // n counts posedges after E0 before we is seen; we in the E32..E33 cycle gives n=32.
  task automatic wait_we(output int n, output bit found, output bit busy_ok);
    n = 0; found = 0; busy_ok = 1;
    while (!found && n <= 60) begin
      if (!busy) busy_ok = 0;
      if (we) found = 1;
      else begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    n_rst = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0; dst = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, we, div_by_zero, wa, wd} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b we=%b dbz=%b wa=%0d wd=%h, want all 0",
               busy, done, we, div_by_zero, wa, wd);
    end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ops(input string name, input logic [1:0] ops[], input logic [31:0] as[],
                          input logic [31:0] bs[], input logic [2:0] ds[]);
    int n; bit found, busy_ok; exp_t e;
    for (int i = 0; i < ops.size(); i++) begin
      drive(ops[i], as[i], bs[i], ds[i]);
      wait_we(n, found, busy_ok);
      e = sb.pop_front();
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL %s[%0d]_timeout: no we within 60 cycles", name, i);
        continue;
      end
      checks++;
      if (n !== e.lat || !busy_ok) begin
        errors++;
        $display("FAIL %s[%0d]_latency: we after %0d edges busy_ok=%b, want %0d busy_ok=1", name, i, n, busy_ok, e.lat);
      end
      checks++;
      if (wd !== e.wd || wa !== e.wa) begin
        errors++;
        $display("FAIL %s[%0d]_data: got wa=%0d wd=%h, want wa=%0d wd=%h", name, i, wa, wd, e.wa, e.wd);
      end
      checks++;
      if (done !== 1'b1 || div_by_zero !== e.dbz) begin
        errors++;
        $display("FAIL %s[%0d]_flags: got done=%b dbz=%b, want done=1 dbz=%b", name, i, done, div_by_zero, e.dbz);
      end
      @(negedge clk);
      checks++;
      if (we !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b0 || wd !== e.wd || wa !== e.wa) begin
        errors++;
        $display("FAIL %s[%0d]_after_wb: got we=%b done=%b busy=%b dbz=%b wa=%0d wd=%h, want 0 0 0 0 %0d %h",
                 name, i, we, done, busy, div_by_zero, wa, wd, e.wa, e.wd);
      end
    end
  endtask

  task automatic test_busy_ignore_and_back_to_back;
    int n, pulses; bit found, busy_ok; exp_t e;
    drive(2'd0, 32'd20, 32'd30, 3'd6);
    repeat (9) @(negedge clk);
    op = 2'd2; a = 32'd50; b = 32'd5; dst = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_we(n, found, busy_ok);
    e = sb.pop_front();
    checks++;
    if (!found || n !== 22 || wd !== e.wd || wa !== e.wa) begin
      errors++;
      $display("FAIL busy_ignore: found=%b n=%0d wa=%0d wd=%h, want found=1 n=22 wa=%0d wd=%h", found, n, wa, wd, e.wa, e.wd);
    end
    @(negedge clk);
    drive(2'd3, 32'd100, 32'd7, 3'd7);
    wait_we(n, found, busy_ok);
    e = sb.pop_front();
    checks++;
    if (!found || n !== 32 || wd !== e.wd || wa !== e.wa) begin
      errors++;
      $display("FAIL back_to_back: found=%b n=%0d wa=%0d wd=%h, want found=1 n=32 wa=%0d wd=%h", found, n, wa, wd, e.wa, e.wd);
    end
    pulses = 0;
    repeat (50) begin
      @(negedge clk);
      if (we) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL extra_writes: got %0d we pulses, want 0", pulses);
    end
  endtask

  task automatic test_reset_mid_op;
    int n, pulses; bit found, busy_ok; exp_t e;
    drive(2'd0, 32'd1234, 32'd5678, 3'd5);
    void'(sb.pop_back());
    repeat (14) @(negedge clk);
    @(posedge clk);
    #1 n_rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, we, div_by_zero, wa, wd} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b we=%b dbz=%b wa=%0d wd=%h, want all 0",
               busy, done, we, div_by_zero, wa, wd);
    end
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (we) pulses++;
    end
    n_rst = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (we) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_write: got %0d we pulses, want 0", pulses);
    end
    drive(2'd2, 32'd9, 32'd3, 3'd4);
    wait_we(n, found, busy_ok);
    e = sb.pop_front();
    checks++;
    if (!found || n !== 32 || wd !== e.wd || wa !== e.wa || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_recover: found=%b n=%0d wa=%0d wd=%h dbz=%b, want found=1 n=32 wa=%0d wd=%h dbz=0",
               found, n, wa, wd, div_by_zero, e.wa, e.wd);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [1:0]  mops[];
    logic [31:0] mas[], mbs[];
    logic [2:0]  mds[];
    test_reset();

    mops = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
    mas  = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, $urandom, $urandom, 32'h80000000};
    mbs  = '{32'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, $urandom, $urandom, 32'd2};
    mds  = '{3'd3, 3'd5, 3'd1, 3'd4, 3'd0, 3'd7, 3'd2};
    test_ops("mul", mops, mas, mbs, mds);

    mops = '{2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3};
    mas  = '{32'd100, 32'd100, 32'd5, 32'd5, 32'hFFFFFFFF, $urandom, 32'd3, 32'hDEADBEEF};
    mbs  = '{32'd7, 32'd7, 32'd0, 32'd0, 32'd1, 32'd12345, 32'd10, 32'hFFFFFFFF};
    mds  = '{3'd1, 3'd6, 3'd2, 3'd0, 3'd3, 3'd4, 3'd5, 3'd7};
    test_ops("div", mops, mas, mbs, mds);

    test_busy_ignore_and_back_to_back();
    test_reset_mid_op();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
